// File: rtl/approx_seq_mult.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle, with a
// per-transaction option to run the low accumulator positions on approximate adder cells.
module approx_seq_mult #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_approx
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   a_sh;
  logic [WIDTH-1:0] b_sh;
  logic            mode;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   sum;

  // Ripple adder, carry-in 0, final carry dropped; low positions swap to the approx cell.
  function automatic logic [PW-1:0] step_add(input logic [PW-1:0] x,
                                             input logic [PW-1:0] y,
                                             input logic          approx);
    logic          c;
    logic [PW-1:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < PW; i++) begin
      if (approx && (i < APPROX_BITS)) begin
        s[i] = (~c & (x[i] | y[i])) | (x[i] & y[i] & c);
        c    = c | (x[i] & y[i]);
      end else begin
        s[i] = x[i] ^ y[i] ^ c;
        c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
    end
    return s;
  endfunction

  // a_sh and b_sh are pre-shifted each step, so bit cnt of B is always b_sh[0].
  assign addend   = b_sh[0] ? a_sh : '0;
  assign sum      = step_add(acc, addend, mode);
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      mode        <= 1'b0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_approx  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (in_valid) begin
            a_sh  <= {{WIDTH{1'b0}}, in_a};
            b_sh  <= in_b;
            mode  <= in_approx;
            acc   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc  <= sum;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            out_product <= sum;
            out_approx  <= mode;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
